// File: rtl/alu_sequencer.sv
// alu_sequencer: keypad-driven operand loader and ALU result latch.
//   Loads operand A and operand B from two keypad digits into an external
//   register bank, runs one ALU operation on them and latches the result.
//   A key wait that lasts KEY_TIMEOUT cycles aborts the sequence.
// Optional feature: define SEQ_WRITEBACK_EN to add a WB state that writes the
//   latched result back to register-bank address 2.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, op_sel                request to begin a calculation and its ALU op
//   key_valid, key_code          keypad strobe and hex digit
//   alu_result, alu_zero         ALU outputs, fed from the bank read ports
//   busy                         high whenever the sequencer is not idle
//   reg_wr_en/addr/data          bank write port (combinational, zero latency)
//   reg_rd_addr_a/b, alu_op      bank read addresses and ALU select (held)
//   result, zero, result_valid   latched ALU outputs and their update pulse
//   timeout_err                  one-cycle pulse when a key wait expires
module alu_sequencer #(
   parameter logic [23:0] KEY_TIMEOUT = 24'd10_000_000,
   parameter logic [1:0]  OP_ADDR_A   = 2'd0,
   parameter logic [1:0]  OP_ADDR_B   = 2'd1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] op_sel,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   output logic       busy,
   output logic       reg_wr_en,
   output logic [1:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic [1:0] reg_rd_addr_a,
   output logic [1:0] reg_rd_addr_b,
   output logic [1:0] alu_op,
   output logic [7:0] result,
   output logic       zero,
   output logic       result_valid,
   output logic       timeout_err
);

   localparam int unsigned CNT_W  = 24;
   localparam int unsigned DATA_W = 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GET_A = 3'd1;
   localparam logic [2:0] S_GET_B = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;
`ifdef SEQ_WRITEBACK_EN
   localparam logic [2:0] S_WB    = 3'd5;
   localparam logic [1:0] WB_ADDR = 2'd2;
`endif

   // Last counter value of a key wait; a key in this cycle still wins.
   localparam logic [CNT_W-1:0] CNT_LAST = KEY_TIMEOUT - CNT_W'(1);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [1:0]        rd_a_q, rd_a_d;
   logic [1:0]        rd_b_q, rd_b_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic              timeout_hit_c;

   assign timeout_hit_c = (cnt_q == CNT_LAST);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         rd_a_q   <= OP_ADDR_A;
         rd_b_q   <= OP_ADDR_B;
         alu_op_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         rd_a_q   <= rd_a_d;
         rd_b_q   <= rd_b_d;
         alu_op_q <= alu_op_d;
      end
   end

   // Next-state, next-register values and the combinational write port.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      result_d    = result_q;
      zero_d      = zero_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      rd_a_d      = rd_a_q;
      rd_b_d      = rd_b_q;
      alu_op_d    = alu_op_q;
      reg_wr_en   = 1'b0;
      reg_wr_addr = OP_ADDR_A;
      reg_wr_data = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_GET_A;
               op_d    = op_sel;
               cnt_d   = '0;
            end
         end

         S_GET_A: begin
            if (key_valid) begin
               reg_wr_en   = 1'b1;
               reg_wr_addr = OP_ADDR_A;
               reg_wr_data = {4'b0000, key_code};
               state_d     = S_GET_B;
               cnt_d       = '0;
            end else if (timeout_hit_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_GET_B: begin
            if (key_valid) begin
               reg_wr_en   = 1'b1;
               reg_wr_addr = OP_ADDR_B;
               reg_wr_data = {4'b0000, key_code};
               state_d     = S_EXEC;
               cnt_d       = '0;
               // Load read addresses and op so they are stable through EXEC.
               rd_a_d      = OP_ADDR_A;
               rd_b_d      = OP_ADDR_B;
               alu_op_d    = op_q;
            end else if (timeout_hit_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Settle cycle for the bank read and the ALU.
         S_EXEC: begin
            rd_a_d   = OP_ADDR_A;
            rd_b_d   = OP_ADDR_B;
            alu_op_d = op_q;
            state_d  = S_LATCH;
         end

         S_LATCH: begin
            result_d = alu_result;
            zero_d   = alu_zero;
            valid_d  = 1'b1;
`ifdef SEQ_WRITEBACK_EN
            state_d  = S_WB;
`else
            state_d  = S_IDLE;
`endif
         end

`ifdef SEQ_WRITEBACK_EN
         // result_q already holds the value latched on the LATCH edge.
         S_WB: begin
            reg_wr_en   = 1'b1;
            reg_wr_addr = WB_ADDR;
            reg_wr_data = result_q;
            state_d     = S_IDLE;
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy          = (state_q != S_IDLE);
   assign result        = result_q;
   assign zero          = zero_q;
   assign result_valid  = valid_q;
   assign timeout_err   = err_q;
   assign reg_rd_addr_a = rd_a_q;
   assign reg_rd_addr_b = rd_b_q;
   assign alu_op        = alu_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: keypad/ALU environment, a per-cycle expectation
// timeline built from transaction plans, and one negedge compare process.
module tb_alu_sequencer;

   localparam int T    = 16;
   localparam int MAXC = 4096;
`ifdef SEQ_WRITEBACK_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] op_sel = 2'd0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [7:0] alu_result;
   logic       alu_zero;
   logic       busy, reg_wr_en, zero, result_valid, timeout_err;
   logic [1:0] reg_wr_addr, reg_rd_addr_a, reg_rd_addr_b, alu_op;
   logic [7:0] reg_wr_data, result;

   alu_sequencer #(
      .KEY_TIMEOUT(24'd16),
      .OP_ADDR_A  (2'd0),
      .OP_ADDR_B  (2'd1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op_sel       (op_sel),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .busy         (busy),
      .reg_wr_en    (reg_wr_en),
      .reg_wr_addr  (reg_wr_addr),
      .reg_wr_data  (reg_wr_data),
      .reg_rd_addr_a(reg_rd_addr_a),
      .reg_rd_addr_b(reg_rd_addr_b),
      .alu_op       (alu_op),
      .result       (result),
      .zero         (zero),
      .result_valid (result_valid),
      .timeout_err  (timeout_err)
   );

   initial forever #5 clk = ~clk;

   // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR.
   function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    alu_fn = a + b;
         2'd1:    alu_fn = a - b;
         2'd2:    alu_fn = a & b;
         default: alu_fn = a | b;
      endcase
   endfunction

   // Register bank environment; it is not touched by rst_n.
   logic [7:0] bank [4] = '{default: 8'h00};
   always @(posedge clk) if (reg_wr_en) bank[reg_wr_addr] <= reg_wr_data;
   assign alu_result = alu_fn(alu_op, bank[reg_rd_addr_a], bank[reg_rd_addr_b]);
   assign alu_zero   = (alu_result == 8'h00);

   // Expected per-cycle outputs.
   bit         exp_busy  [MAXC];
   bit         exp_wr    [MAXC];
   logic [1:0] exp_wa    [MAXC];
   logic [7:0] exp_wd    [MAXC];
   bit         exp_valid [MAXC];
   bit         exp_err   [MAXC];
   logic [7:0] exp_res   [MAXC];
   bit         exp_zero  [MAXC];
   logic [1:0] exp_op    [MAXC];

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int last_valid_cyc = -1;
   int last_err_cyc = -1;
   int n_err_seen = 0;
   int wr2_cnt = 0;
   int n_wb_exp = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic reset_fill(input int a);
      for (int i = a; i < MAXC; i++) begin
         exp_busy[i] = 1'b0; exp_wr[i] = 1'b0; exp_wa[i] = 2'd0; exp_wd[i] = 8'h00;
         exp_valid[i] = 1'b0; exp_err[i] = 1'b0; exp_res[i] = 8'h00;
         exp_zero[i] = 1'b0; exp_op[i] = 2'd0;
      end
   endtask

   task automatic set_busy(input int a, input int b);
      for (int i = a; i <= b && i < MAXC; i++) exp_busy[i] = 1'b1;
   endtask

   task automatic set_wr(input int c, input logic [1:0] addr, input logic [7:0] data);
      if (c < MAXC) begin exp_wr[c] = 1'b1; exp_wa[c] = addr; exp_wd[c] = data; end
   endtask

   task automatic set_from_res(input int a, input logic [7:0] r);
      for (int i = a; i < MAXC; i++) begin exp_res[i] = r; exp_zero[i] = (r == 8'h00); end
   endtask

   task automatic set_from_op(input int a, input logic [1:0] op);
      for (int i = a; i < MAXC; i++) exp_op[i] = op;
   endtask

   // Single compare process: every cycle's outputs against the timeline.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         chk("busy", 32'(busy), 32'(exp_busy[cyc]));
         chk("wr_en", 32'(reg_wr_en), 32'(exp_wr[cyc]));
         if (exp_wr[cyc]) begin
            chk("wr_addr", 32'(reg_wr_addr), 32'(exp_wa[cyc]));
            chk("wr_data", 32'(reg_wr_data), 32'(exp_wd[cyc]));
         end
         chk("result_valid", 32'(result_valid), 32'(exp_valid[cyc]));
         chk("timeout_err", 32'(timeout_err), 32'(exp_err[cyc]));
         chk("result", 32'(result), 32'(exp_res[cyc]));
         chk("zero", 32'(zero), 32'(exp_zero[cyc]));
         chk("alu_op", 32'(alu_op), 32'(exp_op[cyc]));
         chk("rd_addr_a", 32'(reg_rd_addr_a), 32'd0);
         chk("rd_addr_b", 32'(reg_rd_addr_b), 32'd1);
      end
      if (result_valid) last_valid_cyc = cyc;
      if (timeout_err) begin last_err_cyc = cyc; n_err_seen++; end
      if (reg_wr_en && reg_wr_addr == 2'd2) wr2_cnt++;
   end

   task automatic next_cycle();
      @(posedge clk);
      cyc++;
      #1;
      start     = 1'b0;
      key_valid = 1'b0;
      op_sel    = 2'($urandom);
      key_code  = 4'($urandom);
   endtask

   // Plans one transaction from the current (idle) cycle, records its
   // expected outputs, then drives it. da/db >= T means that key never comes.
   task automatic run_txn(input logic [1:0] op, input int da, input int db,
                          input logic [3:0] ka_code, input logic [3:0] kb_code,
                          input bit noise, output int kb_o);
      int s, ka, kb, e;
      logic [7:0] r;
      s = cyc; ka = -100; kb = -100;
      if (da >= T) begin
         set_busy(s + 1, s + T);
         exp_err[s + T + 1] = 1'b1;
         e = s + T + 1;
      end else begin
         ka = s + 1 + da;
         set_busy(s + 1, ka);
         set_wr(ka, 2'd0, {4'h0, ka_code});
         if (db >= T) begin
            set_busy(ka + 1, ka + T);
            exp_err[ka + T + 1] = 1'b1;
            e = ka + T + 1;
         end else begin
            kb = ka + 1 + db;
            set_wr(kb, 2'd1, {4'h0, kb_code});
            r = alu_fn(op, {4'h0, ka_code}, {4'h0, kb_code});
            set_from_op(kb + 1, op);
            exp_valid[kb + 3] = 1'b1;
            set_from_res(kb + 3, r);
            if (WB_EN) begin
               set_busy(ka + 1, kb + 3);
               set_wr(kb + 3, 2'd2, r);
               n_wb_exp++;
               e = kb + 4;
            end else begin
               set_busy(ka + 1, kb + 2);
               e = kb + 3;
            end
         end
      end
      kb_o = kb;
      start  = 1'b1;
      op_sel = op;
      while (cyc < e) begin
         next_cycle();
         if (cyc == ka) begin key_valid = 1'b1; key_code = ka_code; end
         if (cyc == kb) begin key_valid = 1'b1; key_code = kb_code; end
         if (noise && (cyc == ka + 1 || cyc == kb + 2)) begin
            start  = 1'b1;
            op_sel = op ^ 2'b01;
         end
      end
   endtask

   function automatic int pick_delay();
      int k;
      k = int'($urandom_range(0, 7));
      if (k == 0)      pick_delay = T;
      else if (k == 1) pick_delay = T - 1;
      else             pick_delay = int'($urandom_range(0, 3));
   endfunction

   initial begin
      int kb, s, r, errs_before;
      reset_fill(0);
      repeat (3) next_cycle();
      chk("reset_result", 32'(result), 32'h00);
      chk("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // ADD 3 + 5, started on the first edge after reset release.
      run_txn(2'd0, 1, 2, 4'h3, 4'h5, 1'b0, kb);
      next_cycle();
      chk("add_result", 32'(result), 32'h08);
      chk("add_zero", 32'(zero), 32'd0);
      chk("add_latency", 32'(last_valid_cyc - kb), 32'd3);

      // No keys: timeout on the 16th GET_A cycle, visible one cycle later.
      s = cyc;
      run_txn(2'd0, T, 0, 4'h0, 4'h0, 1'b0, kb);
      next_cycle();
      chk("timeout_cycle", 32'(last_err_cyc - s), 32'(T + 1));

      // Key on the exact timeout cycle wins; AND C & A = 8.
      errs_before = n_err_seen;
      run_txn(2'd2, T - 1, 0, 4'hC, 4'hA, 1'b0, kb);
      next_cycle();
      chk("edge_no_timeout", 32'(n_err_seen), 32'(errs_before));
      chk("edge_result", 32'(result), 32'h08);

      // Extra starts with another op while busy: SUB 9 - 4 = 5.
      run_txn(2'd1, 0, 1, 4'h9, 4'h4, 1'b1, kb);
      next_cycle();
      chk("op_kept_result", 32'(result), 32'h05);

      // Reset while in GET_B, keys keep arriving during reset.
      s = cyc;
      r = s + 5;
      set_busy(s + 1, r - 1);
      set_wr(s + 2, 2'd0, 8'h07);
      reset_fill(r);
      start = 1'b1; op_sel = 2'd3;
      next_cycle();
      next_cycle(); key_valid = 1'b1; key_code = 4'h7;
      next_cycle();
      next_cycle();
      next_cycle();
      rst_n = 1'b0; key_valid = 1'b1;
      #1;
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_result", 32'(result), 32'h00);
      next_cycle(); key_valid = 1'b1;
      next_cycle();
      chk("partial_write_kept", 32'(bank[0]), 32'h07);
      rst_n = 1'b1;

      // SUB 2 - 2 = 0 with zero set.
      run_txn(2'd1, 2, 0, 4'h2, 4'h2, 1'b0, kb);
      next_cycle();
      chk("sub_zero_result", 32'(result), 32'h00);
      chk("sub_zero_flag", 32'(zero), 32'd1);

      // Randomized transactions with idle gaps and ignored idle keys.
      repeat (50) begin
         if (cyc < MAXC - 100) begin
            repeat (int'($urandom_range(0, 2))) begin
               next_cycle();
               if ($urandom_range(0, 1) == 1) key_valid = 1'b1;
            end
            run_txn(2'($urandom), pick_delay(), pick_delay(), 4'($urandom), 4'($urandom),
                    bit'($urandom_range(0, 1)), kb);
         end
      end
      repeat (3) next_cycle();
      chk("wb_write_count", 32'(wr2_cnt), 32'(n_wb_exp));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
